// File: rtl/accum_cpu_ctrl.sv
// accum_cpu_ctrl: fetch/decode/execute sequencer for the 16-bit accumulator CPU.
// Owns PC, MAR, IR, MBR and AC; drives a single-port synchronous RAM and a
// combinational ALU. Memory strobes are decoded from the current state only.
module accum_cpu_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 14,
  parameter logic [ADDR_WIDTH-1:0] START_PC = 'h100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [2:0]            alu_sel,
  input  logic [DATA_WIDTH-1:0] alu_out,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] ac,
  output logic [DATA_WIDTH-1:0] ir,
  output logic                  busy,
  output logic                  halted,
  output logic                  illegal_op
);

  // state  | meaning
  // IDLE   | waiting for start
  // FA     | fetch address: read M[PC]
  // FD     | fetch data: IR <= M[PC], PC <= PC+1
  // DEC    | decode / execute single-cycle ops
  // OA     | operand address: read M[X]
  // OD     | operand data: MBR <= M[X]
  // EXA    | AC <= ALU(AC, MBR)
  // WB     | AC <= MBR (load)
  // ST     | write AC to M[X]
  // HALTED | stopped until reset
  typedef enum logic [3:0] {
    S_IDLE, S_FA, S_FD, S_DEC, S_OA, S_OD, S_EXA, S_WB, S_ST, S_HALTED
  } state_t;

  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUBT  = 4'h4;
  localparam logic [3:0] OP_HALT  = 4'h7;
  localparam logic [3:0] OP_SKIP  = 4'h8;
  localparam logic [3:0] OP_JUMP  = 4'h9;
  localparam logic [3:0] OP_CLEAR = 4'hA;

  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;

  localparam int XPAD = ADDR_WIDTH - 12;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] mar, mar_nxt, pc_nxt;
  logic [DATA_WIDTH-1:0] mbr, mbr_nxt, ac_nxt, ir_nxt;

  logic [3:0]            opcode;
  logic [ADDR_WIDTH-1:0] operand;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic                  skip_take;

  logic                  cs_raw, we_raw, oe_raw, ill_raw;
  logic [DATA_WIDTH-1:0] wdata_raw;
  logic [2:0]            sel_raw;

  assign opcode  = ir[15:12];
  assign operand = {{XPAD{1'b0}}, ir[11:0]};
  assign pc_inc  = pc + 1'b1;

  // Skipcond condition on IR[11:10]; code 11 never skips.
  always_comb begin
    skip_take = 1'b0;
    case (ir[11:10])
      2'b00:   skip_take = ac[DATA_WIDTH-1];
      2'b01:   skip_take = (ac == '0);
      2'b10:   skip_take = !ac[DATA_WIDTH-1] && (ac != '0);
      default: skip_take = 1'b0;
    endcase
  end

  // Architectural and sequencing registers; reset aborts any instruction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      pc    <= START_PC;
      mar   <= '0;
      ir    <= '0;
      mbr   <= '0;
      ac    <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      mar   <= mar_nxt;
      ir    <= ir_nxt;
      mbr   <= mbr_nxt;
      ac    <= ac_nxt;
    end
  end

  // Next-state, datapath updates and Moore-decoded strobes.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    mar_nxt   = mar;
    ir_nxt    = ir;
    mbr_nxt   = mbr;
    ac_nxt    = ac;
    cs_raw    = 1'b0;
    we_raw    = 1'b0;
    oe_raw    = 1'b0;
    wdata_raw = '0;
    sel_raw   = 3'b000;
    ill_raw   = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          mar_nxt   = pc;
          state_nxt = S_FA;
        end
      end
      S_FA: begin
        cs_raw    = 1'b1;
        oe_raw    = 1'b1;
        state_nxt = S_FD;
      end
      S_FD: begin
        ir_nxt    = mem_rdata;
        pc_nxt    = pc_inc;
        state_nxt = S_DEC;
      end
      S_DEC: begin
        case (opcode)
          OP_LOAD, OP_ADD, OP_SUBT: begin
            mar_nxt   = operand;
            state_nxt = S_OA;
          end
          OP_STORE: begin
            mar_nxt   = operand;
            state_nxt = S_ST;
          end
          OP_HALT: begin
            state_nxt = S_HALTED;
          end
          OP_CLEAR: begin
            ac_nxt    = '0;
            mar_nxt   = pc;
            state_nxt = S_FA;
          end
          OP_JUMP: begin
            pc_nxt    = operand;
            mar_nxt   = operand;
            state_nxt = S_FA;
          end
          OP_SKIP: begin
            if (skip_take) begin
              pc_nxt  = pc_inc;
              mar_nxt = pc_inc;
            end else begin
              mar_nxt = pc;
            end
            state_nxt = S_FA;
          end
          default: begin
            ill_raw   = 1'b1;
            mar_nxt   = pc;
            state_nxt = S_FA;
          end
        endcase
      end
      S_OA: begin
        cs_raw    = 1'b1;
        oe_raw    = 1'b1;
        state_nxt = S_OD;
      end
      S_OD: begin
        mbr_nxt   = mem_rdata;
        state_nxt = (opcode == OP_LOAD) ? S_WB : S_EXA;
      end
      S_EXA: begin
        sel_raw   = (opcode == OP_SUBT) ? ALU_SUB : ALU_ADD;
        ac_nxt    = alu_out;
        mar_nxt   = pc;
        state_nxt = S_FA;
      end
      S_WB: begin
        ac_nxt    = mbr;
        mar_nxt   = pc;
        state_nxt = S_FA;
      end
      S_ST: begin
        cs_raw    = 1'b1;
        we_raw    = 1'b1;
        wdata_raw = ac;
        mar_nxt   = pc;
        state_nxt = S_FA;
      end
      S_HALTED: begin
        state_nxt = S_HALTED;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Strobes are masked while rst is high so an aborted store never commits.
  assign mem_cs     = cs_raw & ~rst;
  assign mem_we     = we_raw & ~rst;
  assign mem_oe     = oe_raw & ~rst;
  assign mem_wdata  = rst ? '0 : wdata_raw;
  assign alu_sel    = rst ? 3'b000 : sel_raw;
  assign illegal_op = ill_raw & ~rst;

  assign mem_addr = mar;
  assign alu_a    = ac;
  assign alu_b    = mbr;
  assign busy     = (state != S_IDLE) && (state != S_HALTED);
  assign halted   = (state == S_HALTED);

endmodule
